// File: rtl/image_pad_loader_pkg.sv
// +-------------------------------------------------------------------------+
// | Package : lenet_pkg                                                      |
// | Shared sizes, pixel type and loader state encoding for the LeNet layer-1 |
// | image front end.                                                         |
// | Rev     : 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

package lenet_pkg;

    localparam int BITWIDTH = 8;
    localparam int IMG_DIM  = 28;
    localparam int PAD      = 2;
    localparam int PDIM     = IMG_DIM + 2 * PAD;
    localparam int CNT_W    = $clog2(IMG_DIM);

    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef logic [CNT_W-1:0]           pos_t;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } load_state_t;

endpackage

`default_nettype wire

// File: rtl/image_pad_loader_if.sv
// +-------------------------------------------------------------------------+
// | Interface : image_pad_loader_if                                          |
// | Pixel stream in, padded frame out, plus the consumer release handshake.  |
// | Rev       : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
`default_nettype none

interface image_pad_loader_if;
    import lenet_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    pixel_t                      in_pixel;
    logic                        in_last;
    pixel_t [PDIM-1:0][PDIM-1:0] image_padded;
    logic                        image_valid;
    logic                        image_consumed;
    logic                        frame_error;

    modport master (
        output in_valid, in_pixel, in_last, image_consumed,
        input  in_ready, image_padded, image_valid, frame_error
    );

    modport slave (
        input  in_valid, in_pixel, in_last, image_consumed,
        output in_ready, image_padded, image_valid, frame_error
    );

endinterface

`default_nettype wire

// File: rtl/image_pad_loader_pixel_pos_counter.sv
// +-------------------------------------------------------------------------+
// | Module : pixel_pos_counter                                               |
// | Row-major row/col position with enable, synchronous clear, IMG_DIM wrap. |
// | Rev    : 1.0 - initial release                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module pixel_pos_counter
    import lenet_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    input  wire logic i_clr,
    output pos_t      o_row,
    output pos_t      o_col,
    output logic      o_is_final
);

    localparam pos_t c_last = pos_t'(IMG_DIM - 1);

    pos_t r_row;
    pos_t r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (r_col == c_last) begin
                r_col <= '0;
                r_row <= (r_row == c_last) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_is_final = (r_row == c_last) && (r_col == c_last);

endmodule

`default_nettype wire

// File: rtl/image_pad_loader.sv
// +-------------------------------------------------------------------------+
// | Module : image_pad_loader                                                |
// | Loads a 28x28 pixel stream into a zero-bordered 32x32 frame for conv1.   |
// | Optional framing check on in_last: define IMG_LAST_CHECK_EN.             |
// | Rev    : 1.0 - initial release                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module image_pad_loader
    import lenet_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst_n,
    image_pad_loader_if.slave   bus
);

    load_state_t r_state;
    logic        r_image_valid;
    pixel_t      r_mem [IMG_DIM][IMG_DIM];

    pos_t        w_row;
    pos_t        w_col;
    logic        w_is_final;
    logic        w_xfer;
    logic        w_clr;

    wire pixel_t [PDIM-1:0][PDIM-1:0] w_padded;

    assign w_xfer          = bus.in_valid && (r_state == LOAD);
    assign bus.in_ready    = (r_state == LOAD);
    assign bus.image_valid = r_image_valid;

    pixel_pos_counter u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_xfer),
        .i_clr      (w_clr),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_is_final (w_is_final)
    );

`ifdef IMG_LAST_CHECK_EN
    logic r_frame_error;

    // An early in_last restarts the frame; the counter's natural wrap covers the final pixel.
    assign w_clr = w_xfer && bus.in_last && !w_is_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_error <= 1'b0;
        end else if (w_xfer && (bus.in_last != w_is_final)) begin
            r_frame_error <= 1'b1;
        end
    end

    assign bus.frame_error = r_frame_error;
`else
    assign w_clr           = 1'b0;
    assign bus.frame_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LOAD;
            r_image_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_xfer && w_is_final) begin
                        r_state       <= FULL;
                        r_image_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.image_consumed) begin
                        r_state       <= LOAD;
                        r_image_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= LOAD;
                    r_image_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < IMG_DIM; r++) begin
                for (int c = 0; c < IMG_DIM; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (w_xfer) begin
            r_mem[w_row][w_col] <= bus.in_pixel;
        end
    end

    // Border cells are hard zeros; only the interior maps onto storage.
    for (genvar gr = 0; gr < PDIM; gr++) begin : g_row
        for (genvar gc = 0; gc < PDIM; gc++) begin : g_col
            if ((gr >= PAD) && (gr < PAD + IMG_DIM) &&
                (gc >= PAD) && (gc < PAD + IMG_DIM)) begin : g_interior
                assign w_padded[gr][gc] = r_mem[gr-PAD][gc-PAD];
            end else begin : g_border
                assign w_padded[gr][gc] = '0;
            end
        end
    end

    assign bus.image_padded = w_padded;

endmodule

`default_nettype wire
